uart_rx: RTL
============

# uart_rx

Serial UART receiver that consumes the line driven by `uart_tx` and delivers parallel bytes over a valid/ready handshake. It shares the transmitter's runtime configuration set: divider, parity enable, character length and stop bits. Each frame is reported with parity and framing error flags. It sits between the external RX pin, or a TX loopback in test, and the peripheral register/FIFO layer.

## Interface
- No parameters; all configuration is runtime.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx_i` in 1: serial line, asynchronous, idle high.
- `cfg_en_i` in 1: receiver enable.
- `cfg_div_i` in 16: clocks per bit; values below 4 are treated as 4.
- `cfg_parity_en_i` in 1: even parity bit present after data.
- `cfg_bits_i` in 2: data bits; 00=5, 01=6, 10=7, 11=8.
- `cfg_stop_bits_i` in 1: 0 = one stop bit, 1 = two.
- `busy_o` out 1: a frame is in progress (state ≠ IDLE).
- `rx_data_o` out 8: received data, LSB first on the line; unused upper bits are 0.
- `rx_valid_o` out 1: `rx_data_o` and the error flags are valid.
- `rx_ready_i` in 1: consumer accepts the data.
- `rx_parity_err_o` out 1: parity mismatch for the held frame.
- `rx_frame_err_o` out 1: a stop bit was sampled low for the held frame.
- `rx_overrun_o` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx_s`.
- Configuration is latched at start-bit detection and stays constant for the whole frame.
- FSM states are IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: when `cfg_en_i`=1 and `rx_s`=0, latch the configuration, clear the baud counter and go to START.
- START: at count = div/2 (`div>>1`), re-sample `rx_s`.
  - If `rx_s`=1, this is a false start: return to IDLE with no output.
  - Otherwise clear the counter and go to DATA.
- DATA: sample at count = div−1, shifting LSB first. After N bits, go to PARITY if parity is enabled, else to STOP1.
- PARITY: sample the bit. Error when the XOR of the data bits and the parity bit is 1 (even parity).
- STOP1: sample the bit; a low sample sets the frame error. Go to STOP2 if `cfg_stop_bits_i`=1, else the frame completes.
- STOP2: same check as STOP1, then the frame completes.
- Frame completion:
  - If `rx_valid_o`=0: load `rx_data_o` and both error flags, set `rx_valid_o`, return to IDLE.
  - If `rx_valid_o`=1: keep the old data, pulse `rx_overrun_o`, discard the new frame.
- Handshake: `rx_valid_o` clears on a cycle with `rx_valid_o`&&`rx_ready_i`. Data and flags hold until then.
- If the handshake and a completion occur in the same cycle, the new frame is loaded, `rx_valid_o` stays 1, and there is no overrun.
- `cfg_en_i`=0 mid-frame aborts to IDLE at the next clock. Held output data is unaffected.
- Reset values:
  - State is IDLE.
  - `busy_o`, `rx_valid_o`, `rx_parity_err_o`, `rx_frame_err_o` and `rx_overrun_o` are 0.
  - `rx_data_o` is 0x00.
  - Counters and shift register are 0.
- Reset mid-frame discards the frame.

## Timing
- Start detection happens 2 cycles after `rx_i` falls (synchronizer).
- With detection at cycle T:
  - The start bit is verified at T + div/2.
  - Data bit k (0-based) is sampled at T + div/2 + div·(k+1).
- The last stop bit is sampled at T + div/2 + div·(N+P+S), where P∈{0,1} and S∈{1,2}. `rx_valid_o` rises at that cycle + 1.
- `busy_o` is high from T+1 through the last stop sample cycle.
- A new start bit can be detected in the first IDLE cycle after completion, giving back-to-back frames with no gap.
- The baud counter is 16 bits wide and never wraps within a bit, since it is cleared at every sample.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of `rx_s` at count−1, count and count+1. Results are committed at count+1, and all sample points move 1 cycle later. A single-cycle glitch never corrupts a bit.
  - Undefined: single sample at the nominal count; a glitch at the sample cycle is captured as data.

## Test plan
- Loopback from `uart_tx` (div=16, 8 bits, parity on, 1 stop), send 0xA5 → `rx_data_o`=0xA5, `rx_valid_o`=1, both error flags 0, held until `rx_ready_i`=1.
- cfg_bits=00, no parity, 2 stop bits; drive 5'b10110 → `rx_data_o`=0x16. `rx_valid_o` rises 1 cycle after the second stop sample.
- Parity on, parity bit inverted by the bench on 0x3C → `rx_data_o`=0x3C, `rx_parity_err_o`=1. Stop bit forced low → `rx_frame_err_o`=1.
- 3-cycle low pulse on idle line (div=16) → false start: back to IDLE, no `rx_valid_o`, `busy_o` deasserts before count 9.
- Hold `rx_ready_i`=0 and send 0x11 then 0x22 → `rx_data_o` stays 0x11, one-cycle `rx_overrun_o` pulse at the second completion.
- Assert `rst_i` mid-DATA, then send 0x5A → all outputs 0 after reset, then 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX line -> parallel byte with parity/framing flags.
// Latency: rx_valid_o rises 1 cycle after the last stop-bit sample (+1 sample offset with majority voting).
// Backpressure: one-entry output hold; a frame completing while rx_valid_o is still held is dropped with a rx_overrun_o pulse.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_i                  asynchronous serial line, idle high
//   cfg_en_i              receiver enable (low aborts any frame in progress)
//   cfg_div_i             clocks per bit (values below 4 behave as 4)
//   cfg_parity_en_i       even parity bit follows the data bits
//   cfg_bits_i            data bits: 00=5, 01=6, 10=7, 11=8
//   cfg_stop_bits_i       0 = one stop bit, 1 = two
//   busy_o                frame in progress
//   rx_data_o/rx_valid_o/rx_ready_i   received byte and its handshake
//   rx_parity_err_o, rx_frame_err_o   error flags of the held frame
//   rx_overrun_o          one-cycle pulse when a completed frame is discarded
//
// Optional feature: define UART_RX_MAJORITY_EN to take every sample as a
// 2-of-3 vote over three consecutive cycles, committed one cycle late.

module uart_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic        busy_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        rx_parity_err_o,
    output logic        rx_frame_err_o,
    output logic        rx_overrun_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] cnt;
    logic [15:0] div_l;
    logic        par_l;
    logic [1:0]  bits_l;
    logic        stop2_l;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        perr_q;
    logic        ferr_q;

    logic        tick;
    logic        sample;
    logic [15:0] start_tgt;
    logic [15:0] bit_tgt;
    logic [2:0]  last_idx;
    logic        ferr_n;
    logic        fin;

    // Counter is cleared on the cycle a sample is taken, so each bit interval
    // is exactly div_l cycles; the start bit is checked at its midpoint.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;   // hist[0] = rx_s one cycle ago, hist[1] = two cycles ago

    // Vote is committed one cycle after the nominal point so the cycle after
    // it is part of the window; later bits keep the same one-cycle offset.
    assign start_tgt = {1'b0, div_l[15:1]};
    assign sample    = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign start_tgt = {1'b0, div_l[15:1]} - 16'd1;
    assign sample    = rx_s;
`endif
    assign bit_tgt  = div_l - 16'd1;
    assign tick     = (state == START) ? (cnt == start_tgt) : (cnt == bit_tgt);
    assign last_idx = 3'd4 + {1'b0, bits_l};
    assign ferr_n   = ferr_q | ~sample;
    assign fin      = tick && (((state == STOP1) && !stop2_l) || (state == STOP2));
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            cnt             <= 16'd0;
            div_l           <= 16'd0;
            par_l           <= 1'b0;
            bits_l          <= 2'd0;
            stop2_l         <= 1'b0;
            bit_idx         <= 3'd0;
            shreg           <= 8'd0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            rx_data_o       <= 8'd0;
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist            <= 2'b11;
`endif
        end else begin
            rx_meta      <= rx_i;
            rx_s         <= rx_meta;
            rx_overrun_o <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist         <= {hist[0], rx_s};
`endif
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if ((state != IDLE) && !cfg_en_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_en_i && !rx_s) begin
                            div_l   <= (cfg_div_i < 16'd4) ? 16'd4 : cfg_div_i;
                            par_l   <= cfg_parity_en_i;
                            bits_l  <= cfg_bits_i;
                            stop2_l <= cfg_stop_bits_i;
                            cnt     <= 16'd0;
                            bit_idx <= 3'd0;
                            shreg   <= 8'd0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            state   <= START;
                        end
                    end
                    START: begin
                        if (tick) begin
                            cnt   <= 16'd0;
                            state <= sample ? IDLE : DATA;   // high here = false start
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            cnt            <= 16'd0;
                            shreg[bit_idx] <= sample;
                            if (bit_idx == last_idx) begin
                                state <= par_l ? PARITY : STOP1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            cnt    <= 16'd0;
                            // unused upper shreg bits are zero, so the full XOR is safe
                            perr_q <= (^shreg) ^ sample;
                            state  <= STOP1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STOP1: begin
                        if (tick) begin
                            cnt    <= 16'd0;
                            ferr_q <= ferr_n;
                            state  <= stop2_l ? STOP2 : IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STOP2: begin
                        if (tick) begin
                            cnt   <= 16'd0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // Completion: a same-cycle handshake frees the holding slot.
                if (fin) begin
                    if (!rx_valid_o || rx_ready_i) begin
                        rx_data_o       <= shreg;
                        rx_parity_err_o <= perr_q;
                        rx_frame_err_o  <= ferr_n;
                        rx_valid_o      <= 1'b1;
                    end else begin
                        rx_overrun_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
